// File: rtl/regdump_pkg.sv
// Shared types and defaults for the register-file debug dump reader.
package regdump_pkg;

    localparam int unsigned AwDefault = 5;
    localparam int unsigned DwDefault = 32;
    localparam int unsigned CsumSeed  = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StSend = 2'd2,
        StCsum = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output beat stream of the dump reader: valid/ready with index, data and framing flags.
interface regfile_dump_reader_if
    import regdump_pkg::*;
#(
    parameter int unsigned AW = AwDefault,
    parameter int unsigned DW = DwDefault
);
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_is_csum;

    modport master (
        output out_valid, out_idx, out_data, out_last, out_is_csum,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_idx, out_data, out_last, out_is_csum,
        output out_ready
    );
endinterface

// File: rtl/regdump_csum.sv
// Running XOR of dumped words; clear has priority over accumulate.
module regdump_csum
    import regdump_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] csum_o
);
    logic [DW-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clr_i) begin
            csum_d = DW'(CsumSeed);
        end else if (en_i) begin
            csum_d = csum_q ^ data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= DW'(CsumSeed);
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;
endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register index range over the debug read port and streams each word out.
// Optional trailing XOR checksum beat when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int unsigned DW = DwDefault,
    parameter int unsigned AW = AwDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         idx_lo,
    input  logic [AW-1:0]         idx_hi,
    output logic [AW-1:0]         ra_debug,
    input  logic [DW-1:0]         ra_debug_data,
    regfile_dump_reader_if.master dump,
    output logic                  busy,
    output logic                  done
);
`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] end_q, end_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;
    logic          handshake;

`ifdef REGDUMP_CHECKSUM_EN
    logic          csum_clr;
    logic          csum_en;
    logic [DW-1:0] csum_val;

    assign csum_clr = (state_q == StIdle) && start;
    assign csum_en  = (state_q == StRead);

    regdump_csum #(
        .DW (DW)
    ) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (csum_clr),
        .en_i   (csum_en),
        .data_i (ra_debug_data),
        .csum_o (csum_val)
    );
`endif

    assign handshake = dump.out_valid && dump.out_ready;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        end_d      = end_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_d   = idx_lo;
                    end_d   = idx_hi;
                    state_d = StRead;
                end
            end
            StRead: begin
                out_data_d = ra_debug_data;
                out_idx_d  = cur_q;
                // With a checksum beat pending, that beat carries the last flag instead.
                out_last_d = (cur_q == end_q) && !CsumEn;
                state_d    = StSend;
            end
            StSend: begin
                if (handshake) begin
                    if (cur_q != end_q) begin
                        cur_d   = cur_q + AW'(1);
                        state_d = StRead;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        out_data_d = csum_val;
                        out_last_d = 1'b1;
                        state_d    = StCsum;
`else
                        done_d  = 1'b1;
                        state_d = StIdle;
`endif
                    end
                end
            end
            StCsum: begin
                if (handshake) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            end_q      <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            end_q      <= end_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            done_q     <= done_d;
        end
    end

    assign ra_debug       = cur_q;
    assign dump.out_valid = (state_q == StSend) || (state_q == StCsum);
    assign dump.out_idx   = out_idx_q;
    assign dump.out_data  = out_data_q;
    assign dump.out_last  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
    assign dump.out_is_csum = (state_q == StCsum);
`else
    assign dump.out_is_csum = 1'b0;
`endif
    assign busy = (state_q != StIdle);
    assign done = done_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a range-walk model queues expected beats,
// a negedge monitor pops and compares on every accepted beat.
module tb_regfile_dump_reader;
`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CsumOn = 1'b1;
`else
    localparam bit CsumOn = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic        csum;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  idx_lo, idx_hi;
    logic [4:0]  ra_debug;
    logic [31:0] ra_debug_data;
    logic        busy, done;
    logic        rand_ready, ready_fixed, ready_r;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int cyc      = 0;
    int last_hs_cyc = -10;
    beat_t exp_q[$];

    regfile_dump_reader_if #(.AW(5), .DW(32)) dump_if ();

    regfile_dump_reader #(
        .DW (32),
        .AW (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .idx_lo        (idx_lo),
        .idx_hi        (idx_hi),
        .ra_debug      (ra_debug),
        .ra_debug_data (ra_debug_data),
        .dump          (dump_if),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic [31:0] rf_val(int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + i;
    endfunction

    assign ra_debug_data    = rf_val(int'(ra_debug));
    assign dump_if.out_ready = ready_r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        ready_r = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the inclusive range lo..hi modulo 32, optionally followed by an XOR beat.
    task automatic push_model(int lo, int hi);
        int n;
        logic [31:0] x;
        n = ((hi - lo + 32) % 32) + 1;
        x = 32'h0;
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.idx  = 5'((lo + k) % 32);
            b.data = rf_val((lo + k) % 32);
            b.last = (k == n - 1) && !CsumOn;
            b.csum = 1'b0;
            x ^= b.data;
            exp_q.push_back(b);
        end
        if (CsumOn) begin
            beat_t c;
            c.idx  = 5'(hi);
            c.data = x;
            c.last = 1'b1;
            c.csum = 1'b1;
            exp_q.push_back(c);
        end
    endtask

    // Monitor: compares accepted beats, stability under backpressure, and done timing.
    logic        prev_stall = 1'b0;
    logic [4:0]  prev_idx;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            last_hs_cyc = -10;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", dump_if.out_valid, 1);
                check("stall_idx_stable", dump_if.out_idx, prev_idx);
                check("stall_data_stable", dump_if.out_data, prev_data);
                check("stall_last_stable", dump_if.out_last, prev_last);
            end
            if (dump_if.out_valid && dump_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    n_pops++;
                    check("beat_idx", dump_if.out_idx, e.idx);
                    check("beat_data", dump_if.out_data, e.data);
                    check("beat_last", dump_if.out_last, e.last);
                    check("beat_is_csum", dump_if.out_is_csum, e.csum);
                    if (e.last) last_hs_cyc = cyc;
                end
            end
            if (done || cyc == last_hs_cyc + 1) check("done_pulse", done, cyc == last_hs_cyc + 1);
            prev_stall = dump_if.out_valid && !dump_if.out_ready;
            prev_idx   = dump_if.out_idx;
            prev_data  = dump_if.out_data;
            prev_last  = dump_if.out_last;
        end
    end

    task automatic do_start(int lo, int hi);
        idx_lo = 5'(lo);
        idx_hi = 5'(hi);
        start  = 1'b1;
        push_model(lo, hi);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        for (int i = 0; i < budget && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle_within_budget", busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        rst = 1'b1; start = 1'b0; idx_lo = '0; idx_hi = '0;
        rand_ready = 1'b0; ready_fixed = 1'b0; ready_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", dump_if.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ra_debug", ra_debug, 0);
        check("rst_idx", dump_if.out_idx, 0);
        check("rst_data", dump_if.out_data, 0);
        check("rst_last", dump_if.out_last, 0);
        check("rst_is_csum", dump_if.out_is_csum, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic range with first-beat latency.
        ready_fixed = 1'b1;
        do_start(3, 5);
        check("lat_busy_next", busy, 1);
        check("lat_read_no_valid", dump_if.out_valid, 0);
        @(posedge clk);
        #1 check("lat_first_valid", dump_if.out_valid, 1);
        wait_idle(100);

        // Wrap-around through index 0, random backpressure.
        rand_ready = 1'b1;
        do_start(30, 1);
        wait_idle(200);

        // Single beat held under backpressure for 10 cycles.
        rand_ready = 1'b0; ready_fixed = 1'b0;
        @(posedge clk);
        #1 do_start(7, 7);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", dump_if.out_valid, 1);
            @(posedge clk);
            #1;
        end
        ready_fixed = 1'b1;
        @(posedge clk);
        #1 check("single_beat_accepted", busy, 0);
        wait_idle(10);

        // Start while busy is dropped.
        rand_ready = 1'b1;
        do_start(10, 14);
        repeat (3) @(posedge clk);
        #1 check("busy_before_extra_start", busy, 1);
        idx_lo = 5'd0; idx_hi = 5'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(200);

        do_start(1, 2);
        wait_idle(100);

        // Reset during the second SEND of a full dump.
        rand_ready = 1'b0; ready_fixed = 1'b1;
        pops0 = n_pops;
        do_start(0, 31);
        for (int i = 0; i < 20; i++) begin
            if (dump_if.out_valid && n_pops == pops0 + 1) break;
            @(posedge clk);
            #1;
        end
        check("second_send_reached", dump_if.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_valid", dump_if.out_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 do_start(20, 22);
        wait_idle(100);

        // Random ranges with random backpressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            do_start(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            wait_idle(400);
        end

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
